// File: rtl/spi_burst_ctrl.sv
// Burst front-end for an SPI master: buffers host TX words, launches one
// transfer at a time, and queues the received words for the host.
module spi_burst_ctrl #(
  parameter int unsigned DATA_LENGTH    = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_LENGTH-1:0]        tx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [DATA_LENGTH-1:0]        rx_data,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          m_start,
  output logic [DATA_LENGTH-1:0]        m_wdata,
  input  logic                          m_busy,
  input  logic                          m_done,
  input  logic [DATA_LENGTH-1:0]        m_rdata,
  output logic                          active,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    GAP     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_LENGTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [DATA_LENGTH-1:0] tx_mem_d [FIFO_DEPTH];
  logic [DATA_LENGTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [DATA_LENGTH-1:0] rx_mem_d [FIFO_DEPTH];
  logic [PW-1:0]          tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PW-1:0]          rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [LW-1:0]          tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic [TW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [DATA_LENGTH-1:0] m_wdata_q, m_wdata_d;
  logic                   m_start_q, m_start_d;
  logic                   err_q, err_d;
  logic                   active_q, active_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_push, tx_pop, rx_push, rx_pop, err_set;
  logic                   busy_unused;

  // Master busy is informational; sequencing relies on m_done alone.
  assign busy_unused = m_busy;

  always_comb begin
    state_d     = state_q;
    tx_mem_d    = tx_mem_q;
    rx_mem_d    = rx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    tx_level_d  = tx_level_q;
    rx_level_d  = rx_level_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    err_set     = 1'b0;

    tx_push = tx_valid && tx_ready_q;
    tx_pop  = (state_q == LAUNCH);
    rx_push = (state_q == CAPTURE);
    rx_pop  = rx_valid_q && rx_ready;

    case (state_q)
      IDLE: begin
        if (tx_level_q != LW'(0) && rx_level_q < LW'(FIFO_DEPTH)) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d    = WAIT;
        wait_cnt_d = TW'(0);
      end
      WAIT: begin
        if (m_done) begin
          state_d = CAPTURE;
        end else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_set   = 1'b1;
          gap_cnt_d = GW'(0);
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      CAPTURE: begin
        gap_cnt_d = GW'(0);
        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                  gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    // FIFO storage and occupancy; push and pop in one cycle cancel out.
    if (tx_push) begin
      tx_mem_d[tx_wr_ptr_q] = tx_data;
      tx_wr_ptr_d           = tx_wr_ptr_q + PW'(1);
    end
    if (tx_pop) tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
    if (tx_push && !tx_pop)      tx_level_d = tx_level_q + LW'(1);
    else if (!tx_push && tx_pop) tx_level_d = tx_level_q - LW'(1);

    if (rx_push) begin
      rx_mem_d[rx_wr_ptr_q] = m_rdata;
      rx_wr_ptr_d           = rx_wr_ptr_q + PW'(1);
    end
    if (rx_pop) rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
    if (rx_push && !rx_pop)      rx_level_d = rx_level_q + LW'(1);
    else if (!rx_push && rx_pop) rx_level_d = rx_level_q - LW'(1);

    // Start and write data are loaded together so both are valid during LAUNCH.
    m_start_d  = (state_d == LAUNCH);
    m_wdata_d  = (state_d == LAUNCH) ? tx_mem_q[tx_rd_ptr_q] : m_wdata_q;
    err_d      = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    active_d   = (state_d != IDLE);
    tx_ready_d = (tx_level_d < LW'(FIFO_DEPTH));
    rx_valid_d = (rx_level_d != LW'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      tx_level_q  <= '0;
      rx_level_q  <= '0;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      m_wdata_q   <= '0;
      m_start_q   <= 1'b0;
      err_q       <= 1'b0;
      active_q    <= 1'b0;
      tx_ready_q  <= 1'b1;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_level_q  <= tx_level_d;
      rx_level_q  <= rx_level_d;
      wait_cnt_q  <= wait_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      m_wdata_q   <= m_wdata_d;
      m_start_q   <= m_start_d;
      err_q       <= err_d;
      active_q    <= active_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_mem_q[rx_rd_ptr_q];
  assign tx_level = tx_level_q;
  assign rx_level = rx_level_q;
  assign m_start  = m_start_q;
  assign m_wdata  = m_wdata_q;
  assign active   = active_q;
  assign err      = err_q;

endmodule
